// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants and types for the VGA frame monitor.
//   - 640x480 timing constants (line/frame totals and active windows)
//   - monitor lock state enum
//   - in_window helper for half-open coordinate ranges [lo,hi)
package vga_timing_pkg;

    localparam int HTOTAL  = 800;
    localparam int HBP     = 144;
    localparam int HFP     = 784;
    localparam int VTOTAL  = 521;
    localparam int VBP     = 31;
    localparam int VFP     = 511;
    localparam int COLOR_W = 8;
    localparam int CNT_W   = 10;

    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGN    = 2'd1,
        LOCKED   = 2'd2
    } mon_state_e;

    function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (v >= CNT_W'(lo)) && (v < CNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// vga_sync_tracker
//   Rebuilds horizontal/vertical counters from the sync falling edges, checks
//   line and frame lengths and runs the UNLOCKED/ALIGN/LOCKED lock FSM.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     pix_ce_i        pixel strobe; nothing advances without it
//     hsync_i/vsync_i active-low syncs
//     hcnt_o/vcnt_o   coordinate of the pixel sampled on this strobe
//     frame_tick_o    vsync falling edge seen on this strobe
//     frame_ok_o      frame boundary that should publish results
//     fail_o          timing check failure on this strobe
//     locked_o        registered (state == LOCKED)
//     timing_err_o    registered one-clk failure pulse
//     state_o         current FSM state (debug)
module vga_sync_tracker
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = HTOTAL,
    parameter int V_TOTAL     = VTOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    output logic [CNT_W-1:0] hcnt_o,
    output logic [CNT_W-1:0] vcnt_o,
    output logic             frame_tick_o,
    output logic             frame_ok_o,
    output logic             fail_o,
    output logic             locked_o,
    output logic             timing_err_o,
    output mon_state_e       state_o
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [2:0]       LOCK_N = 3'(LOCK_FRAMES);

    logic             hs_prev_q, vs_prev_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             line_armed_q, line_armed_d;
    mon_state_e       state_q, state_d;
    logic [2:0]       good_q, good_d;
    logic             locked_q, locked_d, terr_q, terr_d;
    logic             hs_fall, vs_fall, line_bad, frame_bad, sat_bad, fail, frame_ok;

    // Edge detection, counters and length checks.
    always_comb begin
        hs_fall = pix_ce_i & hs_prev_q & ~hsync_i;
        vs_fall = pix_ce_i & vs_prev_q & ~vsync_i;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (pix_ce_i) begin
            if (hs_fall)                hcnt_d = '0;
            else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 10'd1;
            // vsync edge wins over a coincident hsync edge
            if (vs_fall)                           vcnt_d = '0;
            else if (hs_fall && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
        end
        // First hsync edge after reset or loss of lock has no reference line.
        line_bad  = hs_fall & line_armed_q & (hcnt_q != H_LAST);
        frame_bad = vs_fall & (vcnt_q != V_LAST);
        // hcnt about to saturate: hsync has gone missing
        sat_bad   = pix_ce_i & ~hs_fall & (hcnt_q == CNT_MAX - 10'd1);
        // In UNLOCKED nothing is checked; the first vsync edge is the reference.
        fail      = (state_q != UNLOCKED) & (line_bad | frame_bad | sat_bad);
        line_armed_d = line_armed_q;
        if (fail)         line_armed_d = 1'b0;
        else if (hs_fall) line_armed_d = 1'b1;
    end

    // Lock FSM next state.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            UNLOCKED: begin
                if (vs_fall) begin
                    state_d = ALIGN;
                    good_d  = '0;
                end
            end
            ALIGN: begin
                if (fail) begin
                    state_d = UNLOCKED;
                    good_d  = '0;
                end else if (vs_fall) begin
                    good_d = good_q + 3'd1;
                    if (good_q + 3'd1 >= LOCK_N) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (fail) begin
                    state_d = UNLOCKED;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                good_d  = '0;
            end
        endcase
    end

    // Outputs. Only a clean frame boundary seen while already locked
    // publishes; the boundary that completes the lock does not.
    always_comb begin
        locked_d = (state_d == LOCKED);
        terr_d   = fail;
        frame_ok = vs_fall & (state_q == LOCKED) & ~fail;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            line_armed_q <= 1'b0;
            state_q      <= UNLOCKED;
            good_q       <= '0;
            locked_q     <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            if (pix_ce_i) begin
                hs_prev_q <= hsync_i;
                vs_prev_q <= vsync_i;
            end
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            line_armed_q <= line_armed_d;
            state_q      <= state_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            terr_q       <= terr_d;
        end
    end

    assign hcnt_o       = hcnt_d;
    assign vcnt_o       = vcnt_d;
    assign frame_tick_o = vs_fall;
    assign frame_ok_o   = frame_ok;
    assign fail_o       = fail;
    assign locked_o     = locked_q;
    assign timing_err_o = terr_q;
    assign state_o      = state_q;

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
//   Sink end of a VGA link: tracks timing via vga_sync_tracker and reports,
//   once per clean locked frame, the bounding box of pixels equal to key_color.
//   Ports: clk, rst (sync, active-high), pix_ce, hsync, vsync (active-low),
//     rgb, key_color in; locked, frame_done, bbox_valid, bbox_min_x/max_x,
//     bbox_min_y/max_y, timing_err, checksum, dbg_state (lock FSM) out.
//   Optional: VGA_MON_CHECKSUM_EN adds a 16-bit sum of active-pixel rgb,
//     published with frame_done; otherwise checksum is tied to zero.
//   Assumes V_BP > 0, so the pixel sampled on the vsync edge is never active.
module vga_frame_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = HTOTAL,
    parameter int H_BP        = HBP,
    parameter int H_FP        = HFP,
    parameter int V_TOTAL     = VTOTAL,
    parameter int V_BP        = VBP,
    parameter int V_FP        = VFP,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [COLOR_W-1:0] rgb,
    input  logic [COLOR_W-1:0] key_color,
    output logic               locked,
    output logic               frame_done,
    output logic               bbox_valid,
    output logic [CNT_W-1:0]   bbox_min_x,
    output logic [CNT_W-1:0]   bbox_max_x,
    output logic [CNT_W-1:0]   bbox_min_y,
    output logic [CNT_W-1:0]   bbox_max_y,
    output logic               timing_err,
    output logic [15:0]        checksum,
    output mon_state_e         dbg_state
);

    logic [CNT_W-1:0] hcnt, vcnt, px, py;
    logic             frame_tick, frame_ok, fail, pix_active, key_hit, acc_clr;

    vga_sync_tracker #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .LOCK_FRAMES(LOCK_FRAMES)
    ) u_tracker (
        .clk(clk), .rst(rst), .pix_ce_i(pix_ce), .hsync_i(hsync), .vsync_i(vsync),
        .hcnt_o(hcnt), .vcnt_o(vcnt), .frame_tick_o(frame_tick), .frame_ok_o(frame_ok),
        .fail_o(fail), .locked_o(locked), .timing_err_o(timing_err), .state_o(dbg_state)
    );

    logic [CNT_W-1:0] amin_x_q, amin_x_d, amax_x_q, amax_x_d;
    logic [CNT_W-1:0] amin_y_q, amin_y_d, amax_y_q, amax_y_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] omin_x_q, omin_x_d, omax_x_q, omax_x_d;
    logic [CNT_W-1:0] omin_y_q, omin_y_d, omax_y_q, omax_y_d;
    logic             done_q, done_d, valid_q, valid_d;

    always_comb begin
        pix_active = pix_ce & in_window(hcnt, H_BP, H_FP) & in_window(vcnt, V_BP, V_FP);
        px         = hcnt - CNT_W'(H_BP);
        py         = vcnt - CNT_W'(V_BP);
        key_hit    = pix_active & (rgb == key_color);
        // Accumulators restart at every frame boundary and on any timing failure.
        acc_clr    = fail | frame_tick;

        amin_x_d = amin_x_q; amax_x_d = amax_x_q;
        amin_y_d = amin_y_q; amax_y_d = amax_y_q;
        hit_d    = hit_q;
        if (acc_clr) begin
            amin_x_d = CNT_MAX; amax_x_d = '0;
            amin_y_d = CNT_MAX; amax_y_d = '0;
            hit_d    = 1'b0;
        end else if (key_hit) begin
            if (px < amin_x_q) amin_x_d = px;
            if (px > amax_x_q) amax_x_d = px;
            if (py < amin_y_q) amin_y_d = py;
            if (py > amax_y_q) amax_y_d = py;
            hit_d = 1'b1;
        end

        // Publish; an empty frame leaves the previous box on the outputs.
        done_d   = frame_ok;
        valid_d  = frame_ok ? hit_q : valid_q;
        omin_x_d = omin_x_q; omax_x_d = omax_x_q;
        omin_y_d = omin_y_q; omax_y_d = omax_y_q;
        if (frame_ok && hit_q) begin
            omin_x_d = amin_x_q; omax_x_d = amax_x_q;
            omin_y_d = amin_y_q; omax_y_d = amax_y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            amin_x_q <= CNT_MAX; amax_x_q <= '0;
            amin_y_q <= CNT_MAX; amax_y_q <= '0;
            hit_q    <= 1'b0;
            omin_x_q <= '0; omax_x_q <= '0;
            omin_y_q <= '0; omax_y_q <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            amin_x_q <= amin_x_d; amax_x_q <= amax_x_d;
            amin_y_q <= amin_y_d; amax_y_q <= amax_y_d;
            hit_q    <= hit_d;
            omin_x_q <= omin_x_d; omax_x_q <= omax_x_d;
            omin_y_q <= omin_y_d; omax_y_q <= omax_y_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    assign frame_done = done_q;
    assign bbox_valid = valid_q;
    assign bbox_min_x = omin_x_q;
    assign bbox_max_x = omax_x_q;
    assign bbox_min_y = omin_y_q;
    assign bbox_max_y = omax_y_q;

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, cks_q, cks_d;

    always_comb begin
        sum_d = sum_q;
        if (acc_clr)         sum_d = '0;
        else if (pix_active) sum_d = sum_q + {8'h00, rgb};
        cks_d = frame_ok ? sum_q : cks_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cks_q <= '0;
        end else begin
            sum_q <= sum_d;
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor
//   Drives reduced-size VGA-style frames (32x24 totals, 24x18 active) into
//   vga_frame_monitor. Each frame is described by one coloured rectangle on a
//   background; the expected bounding box, checksum and lock behaviour are
//   derived from that description and kept in an expected queue.
module tb_vga_frame_monitor;
    import vga_timing_pkg::*;

    localparam int H_T = 32, H_B = 6, H_F = 30, HS_W = 3;
    localparam int V_T = 24, V_B = 3, V_F = 21, VS_W = 2;
    localparam int LOCK_N = 2;
    localparam int H_A = H_F - H_B, V_A = V_F - V_B;

    typedef struct {
        int         x0;
        int         y0;
        int         w;
        int         h;
        logic [7:0] col;
        logic [7:0] bg;
        logic [7:0] key;
    } frame_t;

    logic        clk, rst, pix_ce, hsync, vsync;
    logic [7:0]  rgb, key_color;
    logic        locked, frame_done, bbox_valid, timing_err;
    logic [9:0]  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
    logic [15:0] checksum;
    mon_state_e  dbg_state;

    int          n_checks, n_err;
    logic [56:0] exp_q[$];
    logic [56:0] mon_e;
    int          n_vs, exp_terr, terr_cnt;
    frame_t      prev_f;
    logic [9:0]  last_minx, last_maxx, last_miny, last_maxy;

    vga_frame_monitor #(
        .H_TOTAL(H_T), .H_BP(H_B), .H_FP(H_F),
        .V_TOTAL(V_T), .V_BP(V_B), .V_FP(V_F), .LOCK_FRAMES(LOCK_N)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .key_color(key_color), .locked(locked), .frame_done(frame_done),
        .bbox_valid(bbox_valid), .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y), .timing_err(timing_err),
        .checksum(checksum), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: frame_done pulses and timing_err pulses
    always @(negedge clk) begin
        if (timing_err) terr_cnt++;
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                check_eq("frame_done_unexpected", 32'(frame_done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("bbox_valid", 32'(bbox_valid), 32'(mon_e[56]));
                check_eq("bbox_min_x", 32'(bbox_min_x), 32'(mon_e[55:46]));
                check_eq("bbox_max_x", 32'(bbox_max_x), 32'(mon_e[45:36]));
                check_eq("bbox_min_y", 32'(bbox_min_y), 32'(mon_e[35:26]));
                check_eq("bbox_max_y", 32'(bbox_max_y), 32'(mon_e[25:16]));
                check_eq("checksum",   32'(checksum),   32'(mon_e[15:0]));
            end
        end
    end

    // drivers
    task automatic send_pixel(input logic hs, input logic vs, input logic [7:0] c);
        @(negedge clk);
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        if ($urandom_range(0, 7) == 0) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_locked",     32'(locked),     32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_bbox_valid", 32'(bbox_valid), 32'd0);
        check_eq("rst_min_x",      32'(bbox_min_x), 32'd0);
        check_eq("rst_max_x",      32'(bbox_max_x), 32'd0);
        check_eq("rst_min_y",      32'(bbox_min_y), 32'd0);
        check_eq("rst_max_y",      32'(bbox_max_y), 32'd0);
        check_eq("rst_timing_err", 32'(timing_err), 32'd0);
        check_eq("rst_checksum",   32'(checksum),   32'd0);
        check_eq("rst_state",      32'(dbg_state),  32'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst       = 1'b0;
        n_vs      = 0;
        last_minx = '0; last_maxx = '0; last_miny = '0; last_maxy = '0;
    endtask

    // Reference model: a frame boundary publishes the previous frame only when
    // at least LOCK_N+1 boundaries have been seen since reset or the last error.
    task automatic model_frame_start();
        logic       hit;
        int         area, sum;
        logic [15:0] cks;
        if (n_vs >= LOCK_N + 1) begin
            hit  = (prev_f.col == prev_f.key);
            area = prev_f.w * prev_f.h;
            if (hit) begin
                last_minx = 10'(prev_f.x0);
                last_maxx = 10'(prev_f.x0 + prev_f.w - 1);
                last_miny = 10'(prev_f.y0);
                last_maxy = 10'(prev_f.y0 + prev_f.h - 1);
            end
            sum = int'(prev_f.bg) * (H_A * V_A - area) + int'(prev_f.col) * area;
`ifdef VGA_MON_CHECKSUM_EN
            cks = 16'(sum);
`else
            cks = 16'(sum & 0);
`endif
            exp_q.push_back({hit, last_minx, last_maxx, last_miny, last_maxy, cks});
        end
        if (n_vs < 1000) n_vs++;
    endtask

    task automatic draw_frame(input frame_t f, input int short_line, input int rst_line);
        logic [7:0] c;
        int         x, y;
        model_frame_start();
        key_color = f.key;
        for (int v = 0; v < V_T; v++) begin
            for (int h = 0; h < H_T; h++) begin
                if (!(v == short_line && h == H_T - 1)) begin
                    if (v == rst_line && h == H_T / 2) mid_reset();
                    c = 8'h00;
                    if (h >= H_B && h < H_F && v >= V_B && v < V_F) begin
                        x = h - H_B;
                        y = v - V_B;
                        if (x >= f.x0 && x < f.x0 + f.w && y >= f.y0 && y < f.y0 + f.h) c = f.col;
                        else c = f.bg;
                    end
                    // A shortened line is detected at the next hsync edge.
                    if (short_line >= 0 && v == short_line + 1 && h == 0 && n_vs >= 1) begin
                        exp_terr++;
                        n_vs = 0;
                    end
                    send_pixel(h >= HS_W, v >= VS_W, c);
                    if (v == 0 && h == 0)
                        check_eq("locked_at_vs", 32'(locked), 32'(n_vs >= LOCK_N + 1));
                    if (short_line >= 0 && v == short_line + 1 && h == 0) begin
                        #1;
                        check_eq("short_line_terr",   32'(terr_cnt), 32'(exp_terr));
                        check_eq("short_line_locked", 32'(locked),   32'd0);
                    end
                end
            end
        end
        prev_f = f;
    endtask

    task automatic miss_hsync(input int n);
        if (n_vs >= 1) begin
            exp_terr++;
            n_vs = 0;
        end
        repeat (n) send_pixel(1'b1, 1'b1, 8'h00);
        #1;
        check_eq("miss_hsync_terr",   32'(terr_cnt), 32'(exp_terr));
        check_eq("miss_hsync_locked", 32'(locked),   32'd0);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        f.x0  = $urandom_range(0, H_A - 1);
        f.w   = $urandom_range(1, H_A - f.x0);
        f.y0  = $urandom_range(0, V_A - 1);
        f.h   = $urandom_range(1, V_A - f.y0);
        f.col = 8'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            f.key = f.col;
        end else begin
            do f.key = 8'($urandom); while (f.key == f.col);
        end
        do f.bg = 8'($urandom); while (f.bg == f.key);
        return f;
    endfunction

    // main sequence
    initial begin
        frame_t blk, absent, full, rf;
        rst = 1'b1; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1;
        rgb = '0; key_color = '0;
        n_checks = 0; n_err = 0; n_vs = 0; exp_terr = 0; terr_cnt = 0;
        last_minx = '0; last_maxx = '0; last_miny = '0; last_maxy = '0;
        blk    = '{10, 5, 10, 10, 8'hE3, 8'h1C, 8'hE3};
        absent = '{10, 5, 10, 10, 8'h1C, 8'h03, 8'hE3};
        full   = '{0, 0, H_A, V_A, 8'h01, 8'h00, 8'h01};
        prev_f = blk;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (4) send_pixel(1'b1, 1'b1, 8'h00);

        repeat (5) draw_frame(blk, -1, -1);
        draw_frame(absent, -1, -1);
        repeat (4) begin rf = rand_frame(); draw_frame(rf, -1, -1); end
        rf = rand_frame(); draw_frame(rf, 10, -1);
        repeat (4) begin rf = rand_frame(); draw_frame(rf, -1, -1); end
        rf = rand_frame(); draw_frame(rf, -1, 12);
        repeat (4) begin rf = rand_frame(); draw_frame(rf, -1, -1); end
        draw_frame(full, -1, -1);
        draw_frame(blk, -1, -1);
        miss_hsync(1100);
        repeat (4) begin rf = rand_frame(); draw_frame(rf, -1, -1); end
        draw_frame(blk, -1, -1);
        repeat (4) send_pixel(1'b1, 1'b1, 8'h00);
        #1;

        check_eq("terr_total",  32'(terr_cnt),     32'(exp_terr));
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
